fft_frame_ctrl: RTL and testbench
=================================

Name: fft_frame_ctrl

Overview:
Runtime-configurable frame controller that sits between the ADC sample stream and an external pipelined FFT core. It is the successor to the fixed-length FFT controller. Each frame it programs the core's length and direction, then loads one frame of N = 2^cfg_log2_len beats, zero-pads short input frames and truncates long ones. It passes the core output downstream with a bin index, a frame counter and per-frame status flags. The core is instantiated by the parent; this block exposes only its AXI-Stream ports.

Parameters:
MAX_LOG2_LEN, 13, largest supported log2 transform length (min supported is 3).
CHANNELS, 2, number of channels packed side by side in each data beat.
DATA_WIDTH, 32, complex sample width per channel (re in the low half).
INDEX_WIDTH, 16, width of m_index; must be at least MAX_LOG2_LEN.
CONFIG_LATENCY, 4, idle cycles after the config handshake before the first data beat.
CFG_WIDTH, 16, core config word width; must be at least 8+CHANNELS, rounded up to a byte.

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
start  in  1  frame request pulse; honoured only in IDLE
cfg_log2_len  in  5  log2 transform length, sampled on an accepted start
cfg_fwd  in  CHANNELS  per-channel direction (1 = forward), sampled on an accepted start
s_axis_tdata  in  CHANNELS*DATA_WIDTH  input samples
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  input end of frame
s_axis_tready  out  1  input ready
fft_cfg_tdata  out  CFG_WIDTH  core config word
fft_cfg_tvalid  out  1  core config valid
fft_cfg_tready  in  1  core config ready
fft_in_tdata  out  CHANNELS*DATA_WIDTH  core data in
fft_in_tvalid  out  1  core data in valid
fft_in_tlast  out  1  core data in last
fft_in_tready  in  1  core data in ready
fft_out_tdata  in  CHANNELS*DATA_WIDTH  core result
fft_out_tvalid  in  1  core result valid
fft_out_tlast  in  1  core result last
fft_out_tready  out  1  core result ready
m_axis_tdata  out  CHANNELS*DATA_WIDTH  result data
m_axis_tvalid  out  1  result valid
m_axis_tlast  out  1  result last
m_axis_tready  in  1  result ready
m_index  out  INDEX_WIDTH  bin index of the current m_axis beat
frame_count  out  16  completed output frames; wraps
busy  out  1  high in every state except IDLE
flag_padded  out  1  current/last frame was zero-padded
flag_truncated  out  1  current/last frame was truncated
err_cfg  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (async on areset rising, released on aclk): state IDLE. All outputs, counters and flags are 0; s_axis_tready = 0.
- States: IDLE, CONFIG, LOAD, PAD, DISCARD, UNLOAD.
- IDLE:
  - start with 3 <= cfg_log2_len <= MAX_LOG2_LEN: latch the config, load beat counter cnt = N-1, clear both flags, set m_index = 0, go to CONFIG.
  - start with an out-of-range length: err_cfg high for 1 cycle, remain in IDLE.
- CONFIG:
  - fft_cfg_tdata = {zeros, fwd[CHANNELS-1:0] at bits 8+, 3'b0, log2_len[4:0]}.
  - fft_cfg_tvalid is held high until the fft_cfg_tready handshake, then low.
  - After the handshake, wait CONFIG_LATENCY cycles, then go to LOAD.
- LOAD: combinational passthrough.
  - fft_in_tdata = s_axis_tdata; fft_in_tvalid = s_axis_tvalid; s_axis_tready = fft_in_tready.
  - fft_in_tlast = (cnt == 0).
  - cnt decrements on each fft_in handshake.
  - Handshake with cnt == 0 and s_axis_tlast: go to UNLOAD.
  - Handshake with cnt == 0 and no s_axis_tlast: set flag_truncated, go to DISCARD.
  - Handshake with cnt != 0 and s_axis_tlast: set flag_padded, go to PAD.
- PAD:
  - s_axis_tready = 0; fft_in_tdata = 0; fft_in_tvalid = 1; fft_in_tlast = (cnt == 0).
  - cnt decrements per handshake; the handshake at cnt == 0 goes to UNLOAD.
- DISCARD: s_axis_tready = 1, fft_in_tvalid = 0. Input beats are dropped until an s_axis_tlast handshake, then go to UNLOAD (or to IDLE if out_done is already set).
- Output path, all states: m_axis_tdata/tvalid/tlast = fft_out_*; fft_out_tready = m_axis_tready.
  - m_index increments on each m_axis handshake and wraps at 2^INDEX_WIDTH.
  - An m_axis_tlast handshake increments frame_count and sets an internal out_done.
- UNLOAD: exit to IDLE on an m_axis_tlast handshake, or immediately if out_done is set. out_done clears on entry to IDLE.
- Config sampled on a start pulse during busy is ignored; it produces no err_cfg.
- A length-1 input frame (first beat carries tlast) pads N-1 zero beats.
- Flags hold their value until the next accepted start.

Test Plan:
- log2 = 4, 16-beat input with tlast on beat 16: one config handshake, tdata[4:0] = 4. Core receives 16 beats with fft_in_tlast on beat 16; no flags set; frame_count = 1.
- log2 = 4, 10-beat input: 10 data beats followed by 6 zero beats, tlast on beat 16; flag_padded = 1.
- log2 = 3, 12-beat input: 8 beats forwarded, beats 9-12 consumed and dropped; flag_truncated = 1.
- cfg_log2_len = 2 or 14 (MAX = 13): err_cfg pulses once, busy stays 0, no config handshake.
- fft_cfg_tready held low 5 cycles, then random tready/tvalid backpressure on all streams: no beat lost or duplicated; m_index runs 0..N-1; the state returns to IDLE.
- areset asserted mid-LOAD: all outputs 0 on the same cycle; after release, a fresh start completes a normal frame.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// Frame controller in front of an external pipelined FFT core.
// Each frame programs the core's length and direction. It loads exactly
// N = 2^log2_len beats, zero-padding short input frames and dropping the
// tail of long ones. The core's output is forwarded downstream with a bin
// index, a completed-frame counter and per-frame pad/truncate flags.
module fft_frame_ctrl #(
  parameter int MAX_LOG2_LEN   = 13,
  parameter int CHANNELS       = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int INDEX_WIDTH    = 16,
  parameter int CONFIG_LATENCY = 4,
  parameter int CFG_WIDTH      = 16
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           start,
  input  logic [4:0]                     cfg_log2_len,
  input  logic [CHANNELS-1:0]            cfg_fwd,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  output logic                           s_axis_tready,
  output logic [CFG_WIDTH-1:0]           fft_cfg_tdata,
  output logic                           fft_cfg_tvalid,
  input  logic                           fft_cfg_tready,
  output logic [CHANNELS*DATA_WIDTH-1:0] fft_in_tdata,
  output logic                           fft_in_tvalid,
  output logic                           fft_in_tlast,
  input  logic                           fft_in_tready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] fft_out_tdata,
  input  logic                           fft_out_tvalid,
  input  logic                           fft_out_tlast,
  output logic                           fft_out_tready,
  output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready,
  output logic [INDEX_WIDTH-1:0]         m_index,
  output logic [15:0]                    frame_count,
  output logic                           busy,
  output logic                           flag_padded,
  output logic                           flag_truncated,
  output logic                           err_cfg
);

  localparam int CW   = MAX_LOG2_LEN;
  localparam int LATW = (CONFIG_LATENCY < 2) ? 1 : $clog2(CONFIG_LATENCY);
  localparam logic [LATW-1:0] LAT_INIT = (CONFIG_LATENCY > 0) ? LATW'(CONFIG_LATENCY - 1) : '0;
  localparam logic [4:0] MIN_LEN = 5'd3;
  localparam logic [4:0] MAX_LEN = 5'(MAX_LOG2_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_CONFIG, S_LOAD, S_PAD, S_DISCARD, S_UNLOAD
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [4:0]            r_log2;
  logic [CHANNELS-1:0]   r_fwd;
  logic [CW-1:0]         r_cnt;
  logic                  r_cfg_sent;
  logic [LATW-1:0]       r_lat;
  logic                  r_pad;
  logic                  r_trunc;
  logic                  r_out_done;
  logic [INDEX_WIDTH-1:0] r_idx;
  logic [15:0]           r_fcnt;
  logic                  r_err;

  logic                  w_len_ok;
  logic                  w_start_ok;
  logic                  w_start_bad;
  logic [CW-1:0]         w_len_m1;
  logic                  w_cfg_hs;
  logic                  w_in_hs;
  logic                  w_m_hs;
  logic                  w_m_last_hs;
  logic                  w_cnt_zero;
  logic                  w_set_pad;
  logic                  w_set_trunc;
  logic [CFG_WIDTH-1:0]  w_cfg_word;

  // Handshakes are derived from state and inputs only, never from the
  // combinational outputs below, so no feedback loop is formed.
  assign w_len_ok    = (cfg_log2_len >= MIN_LEN) && (cfg_log2_len <= MAX_LEN);
  assign w_start_ok  = start && (r_state == S_IDLE) && w_len_ok;
  assign w_start_bad = start && (r_state == S_IDLE) && !w_len_ok;
  assign w_len_m1    = CW'((32'd1 << cfg_log2_len) - 32'd1);
  assign w_cfg_hs    = (r_state == S_CONFIG) && !r_cfg_sent && fft_cfg_tready;
  assign w_in_hs     = (((r_state == S_LOAD) && s_axis_tvalid) || (r_state == S_PAD)) && fft_in_tready;
  assign w_m_hs      = fft_out_tvalid && m_axis_tready;
  assign w_m_last_hs = w_m_hs && fft_out_tlast;
  assign w_cnt_zero  = (r_cnt == '0);

  // Output path is a straight passthrough from the core in every state.
  assign m_axis_tdata   = fft_out_tdata;
  assign m_axis_tvalid  = fft_out_tvalid;
  assign m_axis_tlast   = fft_out_tlast;
  assign fft_out_tready = m_axis_tready;

  assign m_index        = r_idx;
  assign frame_count    = r_fcnt;
  assign busy           = (r_state != S_IDLE);
  assign flag_padded    = r_pad;
  assign flag_truncated = r_trunc;
  assign err_cfg        = r_err;
  assign fft_cfg_tdata  = w_cfg_word;

  // Core config word: direction bits from bit 8 up, length in bits [4:0].
  always_comb begin
    w_cfg_word = '0;
    w_cfg_word[4:0] = r_log2;
    w_cfg_word[8 +: CHANNELS] = r_fwd;
  end

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and per-state stream steering.
  always_comb begin
    w_state_nxt    = r_state;
    s_axis_tready  = 1'b0;
    fft_in_tdata   = '0;
    fft_in_tvalid  = 1'b0;
    fft_in_tlast   = 1'b0;
    fft_cfg_tvalid = 1'b0;
    w_set_pad      = 1'b0;
    w_set_trunc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_nxt = S_CONFIG;
      end
      S_CONFIG: begin
        fft_cfg_tvalid = !r_cfg_sent;
        if (r_cfg_sent && (r_lat == '0))             w_state_nxt = S_LOAD;
        else if (w_cfg_hs && (CONFIG_LATENCY == 0)) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        s_axis_tready = fft_in_tready;
        fft_in_tdata  = s_axis_tdata;
        fft_in_tvalid = s_axis_tvalid;
        fft_in_tlast  = w_cnt_zero;
        if (w_in_hs) begin
          if (w_cnt_zero) begin
            if (s_axis_tlast) begin
              w_state_nxt = S_UNLOAD;
            end else begin
              w_set_trunc = 1'b1;
              w_state_nxt = S_DISCARD;
            end
          end else if (s_axis_tlast) begin
            w_set_pad   = 1'b1;
            w_state_nxt = S_PAD;
          end
        end
      end
      S_PAD: begin
        fft_in_tvalid = 1'b1;
        fft_in_tlast  = w_cnt_zero;
        if (w_in_hs && w_cnt_zero) w_state_nxt = S_UNLOAD;
      end
      S_DISCARD: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) w_state_nxt = r_out_done ? S_IDLE : S_UNLOAD;
      end
      S_UNLOAD: begin
        if (r_out_done || w_m_last_hs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame setup, config handshake tracking and beat countdown.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_log2     <= '0;
      r_fwd      <= '0;
      r_cnt      <= '0;
      r_cfg_sent <= 1'b0;
      r_lat      <= '0;
    end else if (w_start_ok) begin
      r_log2     <= cfg_log2_len;
      r_fwd      <= cfg_fwd;
      r_cnt      <= w_len_m1;
      r_cfg_sent <= 1'b0;
    end else begin
      if (w_cfg_hs) begin
        r_cfg_sent <= 1'b1;
        r_lat      <= LAT_INIT;
      end else if ((r_state == S_CONFIG) && r_cfg_sent && (r_lat != '0)) begin
        r_lat <= r_lat - LATW'(1);
      end
      if (w_in_hs) r_cnt <= r_cnt - CW'(1);
    end
  end

  // Status: flags, output bin index, frame counter, completion and error pulse.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_pad      <= 1'b0;
      r_trunc    <= 1'b0;
      r_out_done <= 1'b0;
      r_idx      <= '0;
      r_fcnt     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_start_bad;
      if (w_set_pad)   r_pad   <= 1'b1;
      if (w_set_trunc) r_trunc <= 1'b1;
      if (w_m_hs)      r_idx   <= r_idx + INDEX_WIDTH'(1);
      if (w_m_last_hs) r_fcnt  <= r_fcnt + 16'd1;
      if (w_m_last_hs && (r_state != S_IDLE)) r_out_done <= 1'b1;
      // Clearing on entry to IDLE wins over a same-cycle set.
      if ((r_state != S_IDLE) && (w_state_nxt == S_IDLE)) r_out_done <= 1'b0;
      if (w_start_ok) begin
        r_pad   <= 1'b0;
        r_trunc <= 1'b0;
        r_idx   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: random frames against a queue-based reference
// model, with a stand-in FFT core that returns each frame XORed with a key.
module tb_fft_frame_ctrl;

  localparam logic [63:0] KEY = 64'h5A5A_C3C3_0F0F_9696;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [15:0] idx;
  } beat_t;

  typedef struct packed {
    logic        pad;
    logic        trunc;
    logic [15:0] fc;
    logic [15:0] idx;
  } stat_t;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  cfg_log2_len = '0;
  logic [1:0]  cfg_fwd = '0;
  logic [63:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [15:0] fft_cfg_tdata;
  logic        fft_cfg_tvalid;
  logic        fft_cfg_tready = 1'b0;
  logic [63:0] fft_in_tdata;
  logic        fft_in_tvalid;
  logic        fft_in_tlast;
  logic        fft_in_tready = 1'b0;
  logic [63:0] fft_out_tdata = '0;
  logic        fft_out_tvalid = 1'b0;
  logic        fft_out_tlast = 1'b0;
  logic        fft_out_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic [15:0] m_index;
  logic [15:0] frame_count;
  logic        busy;
  logic        flag_padded;
  logic        flag_truncated;
  logic        err_cfg;

  beat_t       exp_in[$];
  beat_t       exp_m[$];
  logic [15:0] exp_cfg[$];
  stat_t       exp_stat[$];
  bit          exp_err[$];
  logic [63:0] core_in[$];
  beat_t       core_out[$];

  int checks = 0;
  int errors = 0;
  bit bp = 1'b0;
  bit cfg_hold = 1'b0;
  bit out_hs = 1'b0;
  bit final_req = 1'b0;
  bit final_done = 1'b0;
  bit busy_prev = 1'b0;
  int exp_fc = 0;

  fft_frame_ctrl #(
    .MAX_LOG2_LEN(13), .CHANNELS(2), .DATA_WIDTH(32),
    .INDEX_WIDTH(16), .CONFIG_LATENCY(4), .CFG_WIDTH(16)
  ) dut (
    .aclk(aclk), .areset(areset), .start(start),
    .cfg_log2_len(cfg_log2_len), .cfg_fwd(cfg_fwd),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .fft_cfg_tdata(fft_cfg_tdata), .fft_cfg_tvalid(fft_cfg_tvalid),
    .fft_cfg_tready(fft_cfg_tready),
    .fft_in_tdata(fft_in_tdata), .fft_in_tvalid(fft_in_tvalid),
    .fft_in_tlast(fft_in_tlast), .fft_in_tready(fft_in_tready),
    .fft_out_tdata(fft_out_tdata), .fft_out_tvalid(fft_out_tvalid),
    .fft_out_tlast(fft_out_tlast), .fft_out_tready(fft_out_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .m_index(m_index), .frame_count(frame_count), .busy(busy),
    .flag_padded(flag_padded), .flag_truncated(flag_truncated),
    .err_cfg(err_cfg)
  );

  initial forever #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT produced a beat/pulse, expected none", name);
  endtask

  // Stand-in core and downstream sink: readies and core output, driven after the edge.
  initial begin
    forever begin
      @(posedge aclk); #1;
      if (areset) begin
        core_out.delete();
        fft_out_tvalid = 1'b0;
        fft_out_tdata  = '0;
        fft_out_tlast  = 1'b0;
      end else begin
        if (out_hs && core_out.size() > 0) begin
          void'(core_out.pop_front());
          fft_out_tvalid = 1'b0;
          fft_out_tdata  = '0;
          fft_out_tlast  = 1'b0;
        end
        if (!fft_out_tvalid && core_out.size() > 0 && (!bp || $urandom_range(3) != 0)) begin
          fft_out_tvalid = 1'b1;
          fft_out_tdata  = core_out[0].data;
          fft_out_tlast  = core_out[0].last;
        end
      end
      fft_cfg_tready = !cfg_hold && (!bp || $urandom_range(1) == 1);
      fft_in_tready  = !bp || ($urandom_range(3) != 0);
      m_axis_tready  = !bp || ($urandom_range(3) != 0);
    end
  end

  // Monitor / scoreboard: samples mid-cycle, pops expectations on every DUT output event.
  initial begin
    beat_t       e;
    beat_t       c;
    stat_t       s;
    logic [15:0] w;
    forever begin
      @(negedge aclk);
      if (areset) begin
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_s_ready", 64'(s_axis_tready), 64'd0);
        check("rst_in_valid", 64'(fft_in_tvalid), 64'd0);
        check("rst_in_last", 64'(fft_in_tlast), 64'd0);
        check("rst_in_data", fft_in_tdata, 64'd0);
        check("rst_cfg_valid", 64'(fft_cfg_tvalid), 64'd0);
        check("rst_cfg_word", 64'(fft_cfg_tdata), 64'd0);
        check("rst_err", 64'(err_cfg), 64'd0);
        check("rst_flags", 64'({flag_padded, flag_truncated}), 64'd0);
        check("rst_fcount", 64'(frame_count), 64'd0);
        check("rst_index", 64'(m_index), 64'd0);
        check("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
        exp_in.delete();
        exp_m.delete();
        exp_cfg.delete();
        exp_stat.delete();
        core_in.delete();
        busy_prev = 1'b0;
        out_hs    = 1'b0;
      end else begin
        out_hs = m_axis_tvalid && m_axis_tready;
        if (fft_cfg_tvalid && fft_cfg_tready) begin
          if (exp_cfg.size() == 0) unexpected("cfg_extra");
          else begin
            w = exp_cfg.pop_front();
            check("cfg_word", 64'(fft_cfg_tdata), 64'(w));
          end
        end
        if (fft_in_tvalid && fft_in_tready) begin
          core_in.push_back(fft_in_tdata);
          if (fft_in_tlast) begin
            for (int i = 0; i < core_in.size(); i++) begin
              c.data = core_in[i] ^ KEY;
              c.last = (i == core_in.size() - 1);
              c.idx  = '0;
              core_out.push_back(c);
            end
            core_in.delete();
          end
          if (exp_in.size() == 0) unexpected("in_extra");
          else begin
            e = exp_in.pop_front();
            check("in_data", fft_in_tdata, e.data);
            check("in_last", 64'(fft_in_tlast), 64'(e.last));
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_m.size() == 0) unexpected("out_extra");
          else begin
            e = exp_m.pop_front();
            check("out_data", m_axis_tdata, e.data);
            check("out_last", 64'(m_axis_tlast), 64'(e.last));
            check("out_index", 64'(m_index), 64'(e.idx));
          end
        end
        if (err_cfg) begin
          if (exp_err.size() == 0) unexpected("err_extra");
          else begin
            void'(exp_err.pop_front());
            check("err_busy", 64'(busy), 64'd0);
          end
        end
        if (busy_prev && !busy) begin
          if (exp_stat.size() == 0) unexpected("stat_extra");
          else begin
            s = exp_stat.pop_front();
            check("flag_padded", 64'(flag_padded), 64'(s.pad));
            check("flag_truncated", 64'(flag_truncated), 64'(s.trunc));
            check("frame_count", 64'(frame_count), 64'(s.fc));
            check("end_index", 64'(m_index), 64'(s.idx));
          end
        end
        busy_prev = busy;
        if (final_req && !final_done) begin
          final_done = 1'b1;
          check("left_in", 64'(exp_in.size()), 64'd0);
          check("left_out", 64'(exp_m.size()), 64'd0);
          check("left_cfg", 64'(exp_cfg.size()), 64'd0);
          check("left_stat", 64'(exp_stat.size()), 64'd0);
          check("left_err", 64'(exp_err.size()), 64'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  // One input beat; occasionally pulses start with junk config, which a busy DUT must ignore.
  task automatic send_beat(input logic [63:0] d, input logic last);
    int gap;
    int waitc;
    gap = bp ? $urandom_range(2) : 0;
    repeat (gap) tick();
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    if ($urandom_range(7) == 0) begin
      start        = 1'b1;
      cfg_log2_len = 5'($urandom_range(31));
      cfg_fwd      = 2'($urandom_range(3));
    end
    waitc = 0;
    forever begin
      @(negedge aclk);
      if (s_axis_tready) break;
      waitc++;
      if (waitc > 5000) begin
        $display("FAIL s_axis_wait: waited %0d cycles, limit 5000", waitc);
        $fatal(1, "input stream stalled");
      end
      tick();
    end
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    start         = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge aclk);
      if (!busy) break;
      n++;
      if (n > 40000) begin
        $display("FAIL idle_wait: busy after %0d cycles, limit 40000", n);
        $fatal(1, "frame never completed");
      end
    end
    tick();
  endtask

  // Reference model: what the core must see and what must come back, from the frame rules.
  task automatic run_frame(input int L, input int K, input logic [1:0] fwd, input bit bpm, input bit stall);
    int          n;
    logic [63:0] din[$];
    logic [4:0]  lv;
    beat_t       e;
    stat_t       s;
    n  = 1 << L;
    lv = 5'(L);
    bp = bpm;
    for (int k = 0; k < K; k++) din.push_back({$urandom, $urandom});
    exp_cfg.push_back({6'd0, fwd, 3'd0, lv});
    for (int i = 0; i < n; i++) begin
      e.data = (i < K) ? din[i] : 64'd0;
      e.last = (i == n - 1);
      e.idx  = '0;
      exp_in.push_back(e);
      e.data = e.data ^ KEY;
      e.idx  = 16'(i);
      exp_m.push_back(e);
    end
    exp_fc++;
    s.pad   = (K < n);
    s.trunc = (K > n);
    s.fc    = 16'(exp_fc);
    s.idx   = 16'(n);
    exp_stat.push_back(s);
    cfg_hold     = stall;
    start        = 1'b1;
    cfg_log2_len = lv;
    cfg_fwd      = fwd;
    tick();
    start = 1'b0;
    if (stall) begin
      repeat (5) tick();
      cfg_hold = 1'b0;
    end
    for (int k = 0; k < K; k++) send_beat(din[k], k == K - 1);
    wait_idle();
  endtask

  task automatic run_bad(input int L);
    bp = 1'b0;
    exp_err.push_back(1'b1);
    start        = 1'b1;
    cfg_log2_len = 5'(L);
    cfg_fwd      = 2'b11;
    tick();
    start = 1'b0;
    repeat (3) tick();
  endtask

  task automatic run_reset_mid_load();
    beat_t       e;
    logic [63:0] d;
    bp = 1'b0;
    exp_cfg.push_back({6'd0, 2'b10, 3'd0, 5'd4});
    start        = 1'b1;
    cfg_log2_len = 5'd4;
    cfg_fwd      = 2'b10;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d      = {$urandom, $urandom};
      e.data = d;
      e.last = 1'b0;
      e.idx  = '0;
      exp_in.push_back(e);
      send_beat(d, 1'b0);
    end
    areset = 1'b1;
    repeat (2) tick();
    areset = 1'b0;
    exp_fc = 0;
    tick();
  endtask

  initial begin
    int rl;
    int rk;
    repeat (3) tick();
    areset = 1'b0;
    tick();

    run_frame(4, 16, 2'b11, 1'b0, 1'b0);
    run_frame(4, 10, 2'b01, 1'b0, 1'b0);
    run_frame(3, 12, 2'b10, 1'b0, 1'b0);
    run_bad(2);
    run_bad(14);
    run_bad(31);
    run_frame(5, 32, 2'b01, 1'b1, 1'b1);
    run_frame(4, 1, 2'b00, 1'b1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      rl = 3 + $urandom_range(3);
      rk = 1 + $urandom_range((1 << rl) + 7);
      run_frame(rl, rk, 2'($urandom_range(3)), 1'b1, r[0]);
    end
    run_frame(13, 8192, 2'b11, 1'b0, 1'b0);
    run_reset_mid_load();
    run_frame(4, 16, 2'b01, 1'b0, 1'b0);

    final_req = 1'b1;
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
